// File: rtl/mem_access_stage.sv
// MEM pipeline stage: store formatting, load alignment/extension and a data-cache request FSM.
// Optional MEM_MISALIGN_CHECK_EN turns misaligned h/w accesses into flagged bubbles with no request.
module mem_access_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_regwrite,
    input  logic [2:0]        ex_funct3,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              istall_n,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wmask,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              dside_stall_n,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_is_load
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              wb_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t            state_q, state_d;
    logic              req_read_q, req_read_d;
    logic              req_write_q, req_write_d;
    logic [DATA_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]        req_mask_q, req_mask_d;
    logic [1:0]        req_off_q, req_off_d;
    logic [2:0]        req_funct3_q, req_funct3_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_is_load_q, wb_is_load_d;
    logic              wb_misalign_q, wb_misalign_d;

    logic              mem_op, misalign, access, in_busy, advance;
    logic [1:0]        off, fmt_off;
    logic [2:0]        fmt_funct3;
    logic [3:0]        mask_now;
    logic [DATA_W-1:0] wdata_now, shifted, load_data;

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
    assign off    = ex_alu_result[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = mem_op & (((ex_funct3[1:0] == 2'b01) & off[0]) |
                                ((ex_funct3[1:0] == 2'b10) & (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign access  = mem_op & ~misalign;
    assign in_busy = (state_q == BUSY);

    // Store lane formatting; halfword/byte masks past lane 3 are truncated by the 4-bit shift.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   mask_now = 4'b0001 << off;
            2'b01:   mask_now = 4'b0011 << off;
            default: mask_now = 4'b1111;
        endcase
        wdata_now = ex_rs2 << {off, 3'b000};
    end

    // While BUSY the request is replayed from the captured copy so the cache sees a stable request.
    always_comb begin
        fmt_off    = in_busy ? req_off_q : off;
        fmt_funct3 = in_busy ? req_funct3_q : ex_funct3;
        shifted    = dmem_rdata >> {fmt_off, 3'b000};
        case (fmt_funct3)
            3'b000:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign dmem_read  = ~rst & (in_busy ? req_read_q  : ((state_q == IDLE) & access & ex_mem_read));
    assign dmem_write = ~rst & (in_busy ? req_write_q : ((state_q == IDLE) & access & ex_mem_write));
    assign dmem_addr  = in_busy ? req_addr_q  : {ex_alu_result[DATA_W-1:2], 2'b00};
    assign dmem_wdata = in_busy ? req_wdata_q : wdata_now;
    assign dmem_wmask = in_busy ? req_mask_q  : mask_now;

    assign dside_stall_n = rst | ~(access & (state_q != HOLD) & ~dmem_resp);
    assign advance       = dside_stall_n & istall_n;

    always_comb begin
        state_d      = state_q;
        req_read_d   = req_read_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_mask_d   = req_mask_q;
        req_off_d    = req_off_q;
        req_funct3_d = req_funct3_q;
        buf_d        = buf_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (dmem_resp) begin
                        if (!istall_n) begin
                            buf_d   = load_data;
                            state_d = HOLD;
                        end
                    end else begin
                        state_d      = BUSY;
                        req_read_d   = ex_mem_read;
                        req_write_d  = ex_mem_write;
                        req_addr_d   = {ex_alu_result[DATA_W-1:2], 2'b00};
                        req_wdata_d  = wdata_now;
                        req_mask_d   = mask_now;
                        req_off_d    = off;
                        req_funct3_d = ex_funct3;
                    end
                end
            end
            BUSY: begin
                if (dmem_resp) begin
                    if (istall_n) begin
                        state_d = IDLE;
                    end else begin
                        buf_d   = load_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (istall_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Without advance a bubble enters MEM/WB so a held instruction never writes back twice.
    always_comb begin
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_rd_d       = 5'd0;
        wb_data_d     = '0;
        wb_is_load_d  = 1'b0;
        wb_misalign_d = 1'b0;
        if (advance) begin
            wb_valid_d    = ex_valid & ~misalign;
            wb_regwrite_d = ex_valid & ex_regwrite & ~ex_mem_write & ~misalign;
            wb_rd_d       = ex_rd;
            wb_is_load_d  = ex_valid & ex_mem_read & ~misalign;
            wb_misalign_d = misalign;
            if (ex_mem_read & ~misalign)
                wb_data_d = (state_q == HOLD) ? buf_q : load_data;
            else
                wb_data_d = ex_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_read_q    <= 1'b0;
            req_write_q   <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_mask_q    <= 4'b0000;
            req_off_q     <= 2'b00;
            req_funct3_q  <= 3'b000;
            buf_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= '0;
            wb_is_load_q  <= 1'b0;
            wb_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_read_q    <= req_read_d;
            req_write_q   <= req_write_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            req_mask_q    <= req_mask_d;
            req_off_q     <= req_off_d;
            req_funct3_q  <= req_funct3_d;
            buf_q         <= buf_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_is_load_q  <= wb_is_load_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_is_load  = wb_is_load_q;

`ifdef MEM_MISALIGN_CHECK_EN
    assign wb_misalign = wb_misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = wb_misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, loads/stores, stalls, HOLD and reset.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_regwrite;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_rs2;
    logic [4:0]  ex_rd;
    logic        istall_n;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp;
    logic        dside_stall_n;
    logic        wb_valid, wb_regwrite, wb_is_load;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        wb_misalign;
`endif

    int checkCount = 0;
    int failCount  = 0;
    int stallCycles;

    mem_access_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_regwrite(ex_regwrite), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .istall_n(istall_n),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dside_stall_n(dside_stall_n),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_is_load(wb_is_load)
`ifdef MEM_MISALIGN_CHECK_EN
        , .wb_misalign(wb_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic rw,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [4:0] dst);
        ex_valid      = valid;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_regwrite   = rw;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_rs2        = rs2;
        ex_rd         = dst;
    endtask

    // Starts at a negedge with the access already applied; returns at the negedge after completion.
    task automatic runMem(input int delay, input logic [31:0] rdata, output int stalls);
        stalls = 0;
        for (int c = 0; c <= delay; c++) begin
            dmem_resp  = (c == delay);
            dmem_rdata = (c == delay) ? rdata : 32'h5A5A_5A5A;
            #1;
            if (!dside_stall_n) stalls++;
            checkOutput("strobeHeld", 32'(dmem_read | dmem_write), 32'd1);
            @(negedge clk);
        end
        dmem_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        istall_n = 1'b1;
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);

        checkOutput("rstWbValid", 32'(wb_valid), 32'd0);
        checkOutput("rstWbRegwrite", 32'(wb_regwrite), 32'd0);
        checkOutput("rstWbRd", 32'(wb_rd), 32'd0);
        checkOutput("rstWbData", wb_data, 32'd0);
        checkOutput("rstWbIsLoad", 32'(wb_is_load), 32'd0);
        checkOutput("rstStallN", 32'(dside_stall_n), 32'd1);
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h0000_1000, 32'h0, 5'd1);
        #1;
        checkOutput("rstReadForced", 32'(dmem_read), 32'd0);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi
        applyStimulus(1, 0, 0, 1, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        #1;
        checkOutput("addiNoRead", 32'(dmem_read), 32'd0);
        checkOutput("addiNoWrite", 32'(dmem_write), 32'd0);
        checkOutput("addiStallN", 32'(dside_stall_n), 32'd1);
        @(negedge clk);
        checkOutput("addiWbValid", 32'(wb_valid), 32'd1);
        checkOutput("addiWbRd", 32'(wb_rd), 32'd5);
        checkOutput("addiWbData", wb_data, 32'h0000_1234);
        checkOutput("addiWbIsLoad", 32'(wb_is_load), 32'd0);

        // lb 0x1003, resp 2 cycles late
        applyStimulus(1, 1, 0, 1, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
        #1;
        checkOutput("lbAddr", dmem_addr, 32'h0000_1000);
        checkOutput("lbRead", 32'(dmem_read), 32'd1);
        runMem(2, 32'h80FF_0000, stallCycles);
        checkOutput("lbStallCycles", 32'(stallCycles), 32'd2);
        checkOutput("lbWbData", wb_data, 32'hFFFF_FF80);
        checkOutput("lbWbValid", 32'(wb_valid), 32'd1);
        checkOutput("lbWbRd", 32'(wb_rd), 32'd7);
        checkOutput("lbWbIsLoad", 32'(wb_is_load), 32'd1);

        // lbu same access
        applyStimulus(1, 1, 0, 1, 3'b100, 32'h0000_1003, 32'h0, 5'd8);
        runMem(2, 32'h80FF_0000, stallCycles);
        checkOutput("lbuStallCycles", 32'(stallCycles), 32'd2);
        checkOutput("lbuWbData", wb_data, 32'h0000_0080);

        // lb offset 1, positive byte, immediate response
        applyStimulus(1, 1, 0, 1, 3'b000, 32'h0000_1001, 32'h0, 5'd8);
        runMem(0, 32'h0000_7F00, stallCycles);
        checkOutput("lbPosStall", 32'(stallCycles), 32'd0);
        checkOutput("lbPosWbData", wb_data, 32'h0000_007F);

        // lh / lhu at offset 2
        applyStimulus(1, 1, 0, 1, 3'b001, 32'h0000_2002, 32'h0, 5'd3);
        runMem(0, 32'h8001_0000, stallCycles);
        checkOutput("lhWbData", wb_data, 32'hFFFF_8001);
        applyStimulus(1, 1, 0, 1, 3'b101, 32'h0000_2002, 32'h0, 5'd3);
        runMem(1, 32'h8001_0000, stallCycles);
        checkOutput("lhuStall", 32'(stallCycles), 32'd1);
        checkOutput("lhuWbData", wb_data, 32'h0000_8001);

        // sh 0x2002
        applyStimulus(1, 0, 1, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd4);
        #1;
        checkOutput("shWrite", 32'(dmem_write), 32'd1);
        checkOutput("shRead", 32'(dmem_read), 32'd0);
        checkOutput("shAddr", dmem_addr, 32'h0000_2000);
        checkOutput("shMask", 32'(dmem_wmask), 32'h0000_000C);
        checkOutput("shWdata", dmem_wdata, 32'hABCD_0000);
        runMem(1, 32'h0, stallCycles);
        checkOutput("shWbRegwrite", 32'(wb_regwrite), 32'd0);
        checkOutput("shWbValid", 32'(wb_valid), 32'd1);

        // sb lane 3 and sw
        applyStimulus(1, 0, 1, 0, 3'b000, 32'h0000_2003, 32'h0000_0012, 5'd0);
        #1;
        checkOutput("sbMask", 32'(dmem_wmask), 32'h0000_0008);
        checkOutput("sbWdata", dmem_wdata, 32'h1200_0000);
        runMem(0, 32'h0, stallCycles);
        applyStimulus(1, 0, 1, 0, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 5'd0);
        #1;
        checkOutput("swAddr", dmem_addr, 32'h0000_2004);
        checkOutput("swMask", 32'(dmem_wmask), 32'h0000_000F);
        checkOutput("swWdata", dmem_wdata, 32'hCAFE_F00D);
        runMem(0, 32'h0, stallCycles);

`ifndef MEM_MISALIGN_CHECK_EN
        // misaligned halfword wraps by mask truncation
        applyStimulus(1, 0, 1, 0, 3'b001, 32'h0000_2003, 32'h0000_ABCD, 5'd0);
        #1;
        checkOutput("shWrapMask", 32'(dmem_wmask), 32'h0000_0008);
        checkOutput("shWrapWdata", dmem_wdata, 32'hCD00_0000);
        runMem(0, 32'h0, stallCycles);
`endif

        // lw with response while istall_n low -> HOLD
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h0000_4000, 32'h0, 5'd9);
        dmem_resp = 1'b0;
        #1;
        checkOutput("holdIssueRead", 32'(dmem_read), 32'd1);
        @(negedge clk);
        dmem_resp = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        istall_n = 1'b0;
        #1;
        checkOutput("holdRespStallN", 32'(dside_stall_n), 32'd1);
        @(negedge clk);
        dmem_resp = 1'b0;
        dmem_rdata = 32'h1111_1111;
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("holdNoReissue", 32'(dmem_read), 32'd0);
            checkOutput("holdBubbleValid", 32'(wb_valid), 32'd0);
            checkOutput("holdBubbleRegwrite", 32'(wb_regwrite), 32'd0);
            @(negedge clk);
        end
        istall_n = 1'b1;
        #1;
        checkOutput("holdReleaseNoRead", 32'(dmem_read), 32'd0);
        @(negedge clk);
        checkOutput("holdWbData", wb_data, 32'hDEAD_BEEF);
        checkOutput("holdWbValid", 32'(wb_valid), 32'd1);
        checkOutput("holdWbRd", 32'(wb_rd), 32'd9);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        checkOutput("holdSingleWb", 32'(wb_valid), 32'd0);

        // reset during BUSY
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h0000_5000, 32'h0, 5'd10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstBusyRead", 32'(dmem_read), 32'd0);
        @(negedge clk);
        checkOutput("rstBusyWbValid", 32'(wb_valid), 32'd0);
        checkOutput("rstBusyWbRd", 32'(wb_rd), 32'd0);
        checkOutput("rstBusyWbData", wb_data, 32'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        dmem_resp = 1'b1;
        #1;
        checkOutput("lateRespRead", 32'(dmem_read), 32'd0);
        checkOutput("lateRespStallN", 32'(dside_stall_n), 32'd1);
        @(negedge clk);
        dmem_resp = 1'b0;
        checkOutput("lateRespWbValid", 32'(wb_valid), 32'd0);
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h0000_5000, 32'h0, 5'd10);
        runMem(1, 32'h0123_4567, stallCycles);
        checkOutput("postRstStall", 32'(stallCycles), 32'd1);
        checkOutput("postRstWbData", wb_data, 32'h0123_4567);
        checkOutput("postRstWbRd", 32'(wb_rd), 32'd10);

`ifdef MEM_MISALIGN_CHECK_EN
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h0000_3002, 32'h0, 5'd11);
        #1;
        checkOutput("misRead", 32'(dmem_read), 32'd0);
        checkOutput("misStallN", 32'(dside_stall_n), 32'd1);
        @(negedge clk);
        checkOutput("misFlag", 32'(wb_misalign), 32'd1);
        checkOutput("misRegwrite", 32'(wb_regwrite), 32'd0);
`endif

        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage sitting directly downstream of the execute stage: consumes the EX/MEM bundle (ALU result/address, forwarded rs2, control), performs the data-side memory access, and drives the registered MEM/WB bundle consumed by writeback and the forwarding unit. It formats store data and byte masks, aligns and sign/zero-extends load data, runs a request/response FSM against the data cache, and generates `dside_stall_n` for the rest of the pipeline.

## Interface
- `DATA_W`, 32, datapath and memory word width
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `ex_valid`  in  1  EX/MEM slot holds a real instruction
- `ex_mem_read` / `ex_mem_write`  in  1 / 1  load / store (from `m` bundle)
- `ex_regwrite`  in  1  instruction writes rd
- `ex_funct3`  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- `ex_alu_result`  in  32  address for ld/st, result otherwise
- `ex_rs2`  in  32  store data (already forwarded)
- `ex_rd`  in  5  destination register
- `istall_n`  in  1  low = instruction side stalled
- `dmem_read` / `dmem_write`  out  1 / 1  cache request strobes
- `dmem_addr`  out  32  word-aligned address (`{addr[31:2],2'b00}`)
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_wmask`  out  4  byte enables
- `dmem_rdata`  in  32  cache read data
- `dmem_resp`  in  1  one-cycle response pulse
- `dside_stall_n`  out  1  low = hold all upstream stages
- `wb_valid`, `wb_regwrite`, `wb_rd`, `wb_data`  out  1,1,5,32  registered MEM/WB bundle
- `wb_is_load`  out  1  wb_data came from memory (forwarding mux select)

## Operation
- FSM states IDLE, BUSY, HOLD. `access = ex_valid & (ex_mem_read | ex_mem_write)`.
- IDLE: if `access`, drive request combinationally this cycle; `dmem_resp` same cycle → complete; else → BUSY.
- BUSY: keep request and all `dmem_*` outputs stable; on `dmem_resp`: if `istall_n` → IDLE, else capture formatted data into a local buffer → HOLD.
- HOLD: no request; wait for `istall_n`, then deliver buffered data, → IDLE. Never reissue.
- `dside_stall_n = !(access & state!=HOLD & !dmem_resp)`; high in IDLE for non-memory ops.
- `advance = dside_stall_n & istall_n`. On advance MEM/WB loads the current instruction; otherwise MEM/WB loads a bubble (`wb_valid=0, wb_regwrite=0`), preventing double writeback.
- Store: `off=addr[1:0]`; wmask b `4'b0001<<off`, h `4'b0011<<off`, w `4'b1111`; wdata `ex_rs2 << 8*off`.
- Load: `rdata >> 8*off`, then sign-extend (b/h) or zero-extend (bu/hu); w unchanged.
- Non-memory: `wb_data = ex_alu_result`. Stores: `wb_regwrite=0`.
- `dmem_read/write` forced 0 while `rst`.

## Timing
- Reset: state IDLE, all `wb_*` 0, buffer 0, `dmem_read/write` 0, `dside_stall_n` 1.
- Non-memory op: 1-cycle latency, in MEM/WB after next edge.
- Load with resp in issue cycle: zero stall cycles; resp after N extra cycles: `dside_stall_n` low exactly N cycles.
- Request strobes never asserted for more than one transaction per instruction.
- Reset mid-BUSY/HOLD: transaction abandoned, strobes drop in the reset cycle, late `dmem_resp` after reset ignored in IDLE with no access.
- `dmem_resp` and `istall_n` low same cycle: go to HOLD, data preserved.

## Configuration
- `MEM_MISALIGN_CHECK_EN`: defined → halfword with `addr[0]=1` or word with `addr[1:0]!=0` issues no request, completes in one cycle as bubble-with-flag: extra output `wb_misalign`=1, `wb_regwrite`=0. Undefined → no check, no `wb_misalign` port; offsets beyond the word wrap via mask shift truncation.

## Test plan
- `addi` result 0x1234, rd=5 → next edge `wb_valid=1, wb_rd=5, wb_data=0x1234`, no dmem strobes.
- `lb` addr 0x1003, rdata 0x80FF_0000, resp 2 cycles late → stall low 2 cycles, `wb_data=0xFFFFFF80`; `lbu` same → 0x00000080.
- `sh` addr 0x2002, rs2 0xABCD → `dmem_addr=0x2000, wmask=4'b1100, wdata=0xABCD0000`, `wb_regwrite=0`.
- `lw` resp while `istall_n=0` 3 cycles → HOLD, one request only, `wb_data=rdata` on first cycle `istall_n=1`; bubbles in WB meanwhile.
- `rst` pulse during BUSY → strobes 0, all `wb_*` 0, subsequent load serviced normally.
- With `MEM_MISALIGN_CHECK_EN`, `lw` addr 0x3002 → no request, `wb_misalign=1`, `wb_regwrite=0`.
